// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mips_multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic [3:0]         ALUCon;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSrc;
  logic               pc_en;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, zero,
    output ALUCon, ALUSrcA, ALUSrcB, PCSrc, pc_en, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero,
    input  ALUCon, ALUSrcA, ALUSrcB, PCSrc, pc_en, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with folded ALU-control decode.
// Define MIPS_IMM_ALU_EN to add the addi/ori immediate execute and writeback states.
module mips_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_multicycle_control_if.master   ctl
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
`ifdef MIPS_IMM_ALU_EN
    ,
    IMMEX  = 4'd10,
    IMMWB  = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_IMM_ALU_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  state_e state_q, state_d;
  logic   illegal;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = FETCH;
    illegal = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (ctl.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE: begin
            if (funct_legal(ctl.funct)) state_d = EXEC;
            else                        illegal = 1'b1;
          end
          OP_BEQ: state_d = BRANCH;
          OP_J:   state_d = JUMP;
`ifdef MIPS_IMM_ALU_EN
          OP_ADDI, OP_ORI: state_d = IMMEX;
`endif
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: state_d = (ctl.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
`ifdef MIPS_IMM_ALU_EN
      IMMEX:  state_d = IMMWB;
`endif
      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  logic [3:0] alu_con;
  logic       alu_src_a, pc_en_raw, iord, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_src_b, pc_src;

  always_comb begin
    alu_con    = ALU_AND;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en_raw  = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_con   = ALU_ADD;
        pc_en_raw = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_con   = ALU_ADD;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_con   = ALU_ADD;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_con   = funct_alu(ctl.funct);
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_con   = ALU_SUB;
        pc_src    = 2'b01;
        pc_en_raw = ctl.zero;
      end
      JUMP: begin
        pc_src    = 2'b10;
        pc_en_raw = 1'b1;
      end
`ifdef MIPS_IMM_ALU_EN
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_con   = (ctl.opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      IMMWB: reg_write = 1'b1;
`endif
      default: ;
    endcase
  end

  // Reset is asynchronous, so enables are gated directly rather than waiting for an edge.
  assign ctl.pc_en      = pc_en_raw & ~reset;
  assign ctl.MemWrite   = mem_write & ~reset;
  assign ctl.IRWrite    = ir_write  & ~reset;
  assign ctl.RegWrite   = reg_write & ~reset;
  assign ctl.illegal_op = illegal   & ~reset;
  assign ctl.ALUCon     = alu_con;
  assign ctl.ALUSrcA    = alu_src_a;
  assign ctl.ALUSrcB    = alu_src_b;
  assign ctl.PCSrc      = pc_src;
  assign ctl.IorD       = iord;
  assign ctl.RegDst     = reg_dst;
  assign ctl.MemtoReg   = mem_to_reg;
  assign ctl.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control; outputs sampled on the falling edge.
module tb_mips_multicycle_control;
  localparam int STATE_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  mips_multicycle_control_if #(.STATE_W(STATE_W)) ctl ();

  mips_multicycle_control #(.STATE_W(STATE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic run_rtype(input logic [5:0] f, input logic [3:0] alu_exp);
    ctl.opcode = 6'b000000;
    ctl.funct  = f;
    check("rt_fetch", 32'(ctl.state), 0);
    next_cycle();
    check("rt_decode", 32'(ctl.state), 1);
    next_cycle();
    check("rt_exec", 32'(ctl.state), 6);
    check("rt_alucon", 32'(ctl.ALUCon), 32'(alu_exp));
    check("rt_srca", 32'(ctl.ALUSrcA), 1);
    check("rt_srcb", 32'(ctl.ALUSrcB), 0);
    check("rt_exec_regwr", 32'(ctl.RegWrite), 0);
    next_cycle();
    check("rt_aluwb", 32'(ctl.state), 7);
    check("rt_regwr", 32'(ctl.RegWrite), 1);
    check("rt_regdst", 32'(ctl.RegDst), 1);
    check("rt_memtoreg", 32'(ctl.MemtoReg), 0);
    next_cycle();
    check("rt_back", 32'(ctl.state), 0);
  endtask

  task automatic run_beq(input logic z, input logic pc_en_exp);
    ctl.opcode = 6'b000100;
    ctl.funct  = 6'b000000;
    ctl.zero   = z;
    next_cycle();
    check("beq_decode", 32'(ctl.state), 1);
    check("beq_decode_pcen", 32'(ctl.pc_en), 0);
    next_cycle();
    check("beq_branch", 32'(ctl.state), 8);
    check("beq_alucon", 32'(ctl.ALUCon), 4'b0110);
    check("beq_pcsrc", 32'(ctl.PCSrc), 2'b01);
    check("beq_pcen", 32'(ctl.pc_en), 32'(pc_en_exp));
    next_cycle();
    check("beq_back", 32'(ctl.state), 0);
    ctl.zero = 1'b0;
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] f);
    ctl.opcode = op;
    ctl.funct  = f;
    check("ill_fetch_flag", 32'(ctl.illegal_op), 0);
    next_cycle();
    check("ill_decode", 32'(ctl.state), 1);
    check("ill_flag", 32'(ctl.illegal_op), 1);
    check("ill_wen", 32'({ctl.pc_en, ctl.MemWrite, ctl.IRWrite, ctl.RegWrite}), 0);
    next_cycle();
    check("ill_back", 32'(ctl.state), 0);
    check("ill_flag_clear", 32'(ctl.illegal_op), 0);
  endtask

`ifdef MIPS_IMM_ALU_EN
  task automatic run_imm(input logic [5:0] op, input logic [3:0] alu_exp);
    ctl.opcode = op;
    next_cycle();
    check("imm_decode", 32'(ctl.state), 1);
    next_cycle();
    check("imm_ex", 32'(ctl.state), 10);
    check("imm_alucon", 32'(ctl.ALUCon), 32'(alu_exp));
    check("imm_srcb", 32'(ctl.ALUSrcB), 2'b10);
    next_cycle();
    check("imm_wb", 32'(ctl.state), 11);
    check("imm_regwr", 32'(ctl.RegWrite), 1);
    check("imm_regdst", 32'(ctl.RegDst), 0);
    next_cycle();
    check("imm_back", 32'(ctl.state), 0);
  endtask
`endif

  initial begin
    reset      = 1'b1;
    ctl.opcode = 6'b000000;
    ctl.funct  = 6'b000000;
    ctl.zero   = 1'b1;
    repeat (2) next_cycle();

    // Reset state: FETCH with its enables suppressed.
    check("rst_state", 32'(ctl.state), 0);
    check("rst_pcen", 32'(ctl.pc_en), 0);
    check("rst_irwrite", 32'(ctl.IRWrite), 0);
    check("rst_memwrite", 32'(ctl.MemWrite), 0);
    check("rst_regwrite", 32'(ctl.RegWrite), 0);
    check("rst_alucon", 32'(ctl.ALUCon), 4'b0010);
    check("rst_srcb", 32'(ctl.ALUSrcB), 2'b01);

    // lw: 0,1,2,3,4,0
    reset      = 1'b0;
    ctl.zero   = 1'b0;
    ctl.opcode = 6'b100011;
    #1;
    check("lw_fetch", 32'(ctl.state), 0);
    check("lw_irwrite", 32'(ctl.IRWrite), 1);
    check("lw_pcen", 32'(ctl.pc_en), 1);
    check("lw_fetch_alucon", 32'(ctl.ALUCon), 4'b0010);
    next_cycle();
    check("lw_decode", 32'(ctl.state), 1);
    check("lw_decode_alucon", 32'(ctl.ALUCon), 4'b0010);
    check("lw_decode_srcb", 32'(ctl.ALUSrcB), 2'b11);
    next_cycle();
    check("lw_memadr", 32'(ctl.state), 2);
    check("lw_memadr_alucon", 32'(ctl.ALUCon), 4'b0010);
    check("lw_memadr_srcb", 32'(ctl.ALUSrcB), 2'b10);
    check("lw_memadr_regwr", 32'(ctl.RegWrite), 0);
    next_cycle();
    check("lw_memrd", 32'(ctl.state), 3);
    check("lw_iord", 32'(ctl.IorD), 1);
    check("lw_memrd_regwr", 32'(ctl.RegWrite), 0);
    next_cycle();
    check("lw_memwb", 32'(ctl.state), 4);
    check("lw_regwr", 32'(ctl.RegWrite), 1);
    check("lw_memtoreg", 32'(ctl.MemtoReg), 1);
    check("lw_regdst", 32'(ctl.RegDst), 0);
    next_cycle();
    check("lw_back", 32'(ctl.state), 0);
    check("lw_back_memtoreg", 32'(ctl.MemtoReg), 0);

    // R-type: each supported funct and its ALU encoding
    run_rtype(6'b101010, 4'b0111);
    run_rtype(6'b100010, 4'b0110);
    run_rtype(6'b100000, 4'b0010);
    run_rtype(6'b100100, 4'b0000);
    run_rtype(6'b100101, 4'b0001);

    // beq taken and not taken
    run_beq(1'b1, 1'b1);
    run_beq(1'b0, 1'b0);

    // j: 0,1,9,0
    ctl.opcode = 6'b000010;
    next_cycle();
    check("j_decode", 32'(ctl.state), 1);
    next_cycle();
    check("j_jump", 32'(ctl.state), 9);
    check("j_pcsrc", 32'(ctl.PCSrc), 2'b10);
    check("j_pcen", 32'(ctl.pc_en), 1);
    next_cycle();
    check("j_back", 32'(ctl.state), 0);

    // Illegal instructions
    run_illegal(6'b000000, 6'b000000);
    run_illegal(6'b111111, 6'b000000);
`ifdef MIPS_IMM_ALU_EN
    run_imm(6'b001101, 4'b0001);
    run_imm(6'b001000, 4'b0010);
`else
    run_illegal(6'b001101, 6'b000000);
    run_illegal(6'b001000, 6'b000000);
`endif

    // sw full pass: 0,1,2,5,0
    ctl.opcode = 6'b101011;
    next_cycle();
    check("sw_decode", 32'(ctl.state), 1);
    next_cycle();
    check("sw_memadr", 32'(ctl.state), 2);
    next_cycle();
    check("sw_memwr", 32'(ctl.state), 5);
    check("sw_memwrite", 32'(ctl.MemWrite), 1);
    check("sw_iord", 32'(ctl.IorD), 1);
    next_cycle();
    check("sw_back", 32'(ctl.state), 0);

    // sw with reset raised in MEMWR: write strobe drops without a clock edge
    repeat (3) next_cycle();
    check("swr_memwr", 32'(ctl.state), 5);
    check("swr_memwrite_pre", 32'(ctl.MemWrite), 1);
    #1 reset = 1'b1;
    #1;
    check("swr_memwrite_async", 32'(ctl.MemWrite), 0);
    check("swr_state_async", 32'(ctl.state), 0);
    check("swr_irwrite_in_rst", 32'(ctl.IRWrite), 0);
    next_cycle();
    reset      = 1'b0;
    ctl.opcode = 6'b000010;
    #1;
    check("swr_release_state", 32'(ctl.state), 0);
    check("swr_release_irwrite", 32'(ctl.IRWrite), 1);
    next_cycle();
    check("swr_next_decode", 32'(ctl.state), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multicycle MIPS control FSM that drives the ALU's ALUCon input and the datapath enables.
- Consumes opcode and funct from the instruction register and zero from the ALU.
- Sequences fetch, decode, execute, memory and writeback cycles.
- Folds the ALU-control decode in, so ALUCon encodings match the ALU exactly: add 0010, sub 0110, or 0001, and 0000, slt 0111.

Parameters:
- STATE_W, 4, width of the state register and the state debug output.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state FETCH
- opcode  in  6  instr[31:26]; stable from DECODE until next FETCH
- funct  in  6  instr[5:0]; same stability
- zero  in  1  ALU zero flag
- ALUCon  out  4  ALU operation select
- ALUSrcA  out  1  0=PC, 1=regA
- ALUSrcB  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
- PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_en  out  1  PC write enable
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  0=rt, 1=rd
- MemtoReg  out  1  0=ALUOut, 1=MDR
- RegWrite  out  1  register-file write
- illegal_op  out  1  one-cycle pulse on unsupported instruction
- state  out  STATE_W  current state, for debug

Behaviour:
- Moore outputs are decoded from state. pc_en is the only exception: in BRANCH it equals zero.
- While reset is high: state=FETCH, and pc_en, MemWrite, IRWrite, RegWrite and illegal_op are forced to 0. Other outputs show FETCH values.
- Any output not listed for a state below is 0.
- States and codes:
  - FETCH=0: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUCon=0010, PCSrc=00, pc_en=1. Next state DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUCon=0010 (branch target). Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> EXEC if funct is one of 100000, 100010, 100100, 100101, 101010; otherwise FETCH with illegal_op=1
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - anything else -> FETCH with illegal_op=1
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUCon=0010. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD=3: IorD=1. Next state MEMWB.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
  - MEMWR=5: IorD=1, MemWrite=1. Next state FETCH.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00. ALUCon from funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111. Next state ALUWB.
  - ALUWB=7: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUCon=0110, PCSrc=01, pc_en=zero. Next state FETCH.
  - JUMP=9: PCSrc=10, pc_en=1. Next state FETCH.
- Latency in cycles, FETCH to FETCH: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
- illegal_op is high only during the DECODE cycle that rejects the instruction.
- Unreachable state codes (10-15 without the feature, 12-15 with it) return to FETCH on the next clock with all enables at 0.
- Reset asserted mid-instruction: write enables drop in the same cycle, because reset is asynchronous. After release, the first cycle is FETCH.
- zero is sampled only in BRANCH and ignored in every other state.

Optional Feature:
- Macro: MIPS_IMM_ALU_EN.
- Defined: DECODE maps opcode 001000 (addi) and 001101 (ori) to IMMEX=10.
  - IMMEX: ALUSrcA=1, ALUSrcB=10, ALUCon=0010 for addi, 0001 for ori. Next state IMMWB=11.
  - IMMWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
  - Latency 4 cycles.
- Undefined: both opcodes are illegal (illegal_op pulse, return to FETCH), and codes 10 and 11 are unreachable.

Test Plan:
- Release reset, opcode=100011 -> states 0,1,2,3,4,0. ALUCon=0010 in 0/1/2. IorD=1 in state 3. RegWrite=1 and MemtoReg=1 only in state 4.
- opcode=000000, funct=101010 -> states 0,1,6,7,0. ALUCon=0111 in state 6. RegWrite=1 and RegDst=1 in state 7. Repeat for funct 100010 -> ALUCon=0110.
- opcode=000100 with zero=1, then with zero=0 -> in BRANCH, ALUCon=0110 and PCSrc=01, with pc_en=1 and 0 respectively. 3-cycle loop each.
- opcode=000000, funct=000000, then opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE. Next state FETCH. No write enable asserted.
- opcode=101011, reset raised during MEMWR -> MemWrite falls with no clock edge. After release, state=0 with IRWrite=1.
- opcode=001101 with MIPS_IMM_ALU_EN defined -> states 0,1,10,11,0 with ALUCon=0001 in state 10. Without the macro -> illegal_op pulse.
